fetch_stage: RTL

Upstream neighbour of the decode stage in the SEQ Y86-64 processor. Holds the program counter and a byte-addressed instruction memory. Once per `step` pulse it fetches the instruction at PC and registers `opcode`, `rArB`, `valC`, `valP` and a status code for decode and later stages. A stat-driven FSM stops fetching on halt, address error or invalid instruction; the memory is loaded through a byte-write port while the stage is idle.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/instr_align.sv | 30 +++
 rtl/fetch_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, status codes and instruction lengths.
// Used by the fetch stage and by the decode stage.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  localparam logic [3:0] RNONE = 4'hF;

  // Undefined icodes report length 1 so the range check only covers the opcode byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: return 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     return 4'd10;
      I_JXX, I_CALL:                    return 4'd9;
      default:                          return 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/instr_align.sv
// Splits a 10-byte instruction window into register byte and constant word.
// Byte 0 of the window is the byte at PC.
module instr_align
  import y86_pkg::*;
(
  input  logic [79:0] window,
  input  logic [3:0]  icode,
  output logic [7:0]  rarb,
  output logic [63:0] valc,
  output logic [3:0]  len,
  output logic        need_reg
);

  always_comb begin
    need_reg = 1'b0;
    valc     = '0;
    case (icode)
      I_CMOVXX, I_OPQ, I_PUSHQ, I_POPQ: need_reg = 1'b1;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
        need_reg = 1'b1;
        valc     = window[79:16];
      end
      I_JXX, I_CALL: valc = window[71:8];
      default: ;
    endcase
    rarb = need_reg ? window[15:8] : {RNONE, RNONE};
    len  = instr_len(icode);
  end

endmodule

// File: rtl/fetch_stage.sv
// SEQ Y86-64 fetch stage: PC register, byte-loadable instruction memory and a
// stat-driven IDLE/RUN/STOP controller that registers one fetch per step.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic          step,
  input  logic          pc_we,
  input  logic [63:0]   pc_in,
  output logic [7:0]    opcode,
  output logic [7:0]    rArB,
  output logic [63:0]   valC,
  output logic [63:0]   valP,
  output logic [63:0]   pc,
  output logic [1:0]    stat,
  output logic          valid,
  output logic          running
);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  localparam logic [63:0] MemLimit = 64'(MEM_BYTES);

  state_e      st_q, st_d;
  logic [63:0] pc_q, pc_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  rarb_q, rarb_d;
  logic [63:0] valc_q, valc_d;
  logic [63:0] valp_q, valp_d;
  logic [1:0]  stat_q, stat_d;
  logic        valid_q, valid_d;

  logic [7:0]  mem [MEM_BYTES];
  logic [79:0] window;
  logic [3:0]  icode, ifun, len;
  logic [7:0]  a_rarb;
  logic [63:0] a_valc, last_addr;
  logic        need_reg, adr, ins;
  logic [1:0]  f_stat;

  // Contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (!rst && load_en && st_q == StIdle && 64'(load_addr) < MemLimit) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < 10; i++) begin
      window[8*i +: 8] = ((pc_q + 64'(i)) < MemLimit) ? mem[AW'(pc_q + 64'(i))] : 8'h00;
    end
  end

  assign icode = window[7:4];
  assign ifun  = window[3:0];

  instr_align u_align (
    .window   (window),
    .icode    (icode),
    .rarb     (a_rarb),
    .valc     (a_valc),
    .len      (len),
    .need_reg (need_reg)
  );

  // First check keeps the second from overflowing near 2^64.
  assign last_addr = pc_q + 64'(len) - 64'd1;
  assign adr       = (pc_q >= MemLimit) || (last_addr >= MemLimit);

  always_comb begin
    case (icode)
      I_CMOVXX, I_JXX: ins = (ifun > 4'd6);
      I_OPQ:           ins = (ifun > 4'd3);
      default:         ins = (icode > I_POPQ) || (ifun != 4'd0);
    endcase
    if (adr)                 f_stat = S_ADR;
    else if (ins)            f_stat = S_INS;
    else if (icode == I_HALT) f_stat = S_HLT;
    else                     f_stat = S_AOK;
  end

  always_comb begin
    st_d     = st_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    rarb_d   = rarb_q;
    valc_d   = valc_q;
    valp_d   = valp_q;
    stat_d   = stat_q;
    valid_d  = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d   = StRun;
          pc_d   = '0;
          stat_d = S_AOK;
        end
      end
      StRun: begin
        if (step) begin
          valid_d  = 1'b1;
          stat_d   = f_stat;
          opcode_d = window[7:0];
          if (f_stat == S_ADR || f_stat == S_INS) begin
            rarb_d = {RNONE, RNONE};
            valc_d = '0;
            valp_d = pc_q;
          end else begin
            rarb_d = a_rarb;
            valc_d = a_valc;
            valp_d = pc_q + 64'(len);
          end
          if (f_stat != S_AOK) st_d = StStop;
        end
        if (pc_we) pc_d = pc_in;
      end
      StStop: ;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= StIdle;
      pc_q     <= '0;
      opcode_q <= {I_NOP, 4'h0};
      rarb_q   <= {RNONE, RNONE};
      valc_q   <= '0;
      valp_q   <= '0;
      stat_q   <= S_AOK;
      valid_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      rarb_q   <= rarb_d;
      valc_q   <= valc_d;
      valp_q   <= valp_d;
      stat_q   <= stat_d;
      valid_q  <= valid_d;
    end
  end

  assign opcode  = opcode_q;
  assign rArB    = rarb_q;
  assign valC    = valc_q;
  assign valP    = valp_q;
  assign pc      = pc_q;
  assign stat    = stat_q;
  assign valid   = valid_q;
  assign running = (st_q == StRun);

endmodule
